rs_alu: RTL and testbench

- Reservation station for the integer/branch ALU in the out-of-order core.
- Buffers dispatched ALU instructions until both source operands are resolved.
- Snoops the two CDB broadcast buses (ALU, LSB) to capture operands, then issues one ready entry per cycle to the ALU as op/v1/v2/rob_id.
- Sits between dispatch/decode (upstream) and the ALU (downstream).

---
 rtl/rs_alu_if.sv | 46 ++++
 rtl/rs_alu.sv | 243 ++++++++++++++++++++++++
 tb/tb_rs_alu.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_alu_if.sv
// rs_alu_if: dispatch, CDB snoop and issue signals of the ALU reservation station.
// master = upstream/environment side, slave = reservation station side.
interface rs_alu_if #(
    parameter int ROB_SIZE_WIDTH = 4
);
    // dispatch from decode
    logic                      dispatch_valid;
    logic [4:0]                dispatch_op;
    logic [ROB_SIZE_WIDTH-1:0] dispatch_rob_id;
    logic [31:0]               dispatch_v1;
    logic [31:0]               dispatch_v2;
    logic                      dispatch_p1;
    logic                      dispatch_p2;
    logic [ROB_SIZE_WIDTH-1:0] dispatch_q1;
    logic [ROB_SIZE_WIDTH-1:0] dispatch_q2;
    logic                      full;
    // common data buses
    logic                      alu_cdb_ready;
    logic [ROB_SIZE_WIDTH-1:0] alu_cdb_rob_id;
    logic [31:0]               alu_cdb_result;
    logic                      lsb_cdb_ready;
    logic [ROB_SIZE_WIDTH-1:0] lsb_cdb_rob_id;
    logic [31:0]               lsb_cdb_result;
    // issue to the ALU
    logic                      issue_valid;
    logic [4:0]                issue_op;
    logic [31:0]               issue_v1;
    logic [31:0]               issue_v2;
    logic [ROB_SIZE_WIDTH-1:0] issue_rob_id;

    modport master (
        output dispatch_valid, dispatch_op, dispatch_rob_id, dispatch_v1, dispatch_v2,
               dispatch_p1, dispatch_p2, dispatch_q1, dispatch_q2,
               alu_cdb_ready, alu_cdb_rob_id, alu_cdb_result,
               lsb_cdb_ready, lsb_cdb_rob_id, lsb_cdb_result,
        input  full, issue_valid, issue_op, issue_v1, issue_v2, issue_rob_id
    );

    modport slave (
        input  dispatch_valid, dispatch_op, dispatch_rob_id, dispatch_v1, dispatch_v2,
               dispatch_p1, dispatch_p2, dispatch_q1, dispatch_q2,
               alu_cdb_ready, alu_cdb_rob_id, alu_cdb_result,
               lsb_cdb_ready, lsb_cdb_rob_id, lsb_cdb_result,
        output full, issue_valid, issue_op, issue_v1, issue_v2, issue_rob_id
    );
endinterface

// File: rtl/rs_alu.sv
// rs_alu: reservation station for the integer/branch ALU.
// Holds dispatched instructions until both operands are resolved (snooping the ALU
// and LSB CDBs), then issues one ready entry per cycle.
// Optional macro RS_AGE_ORDER_EN: oldest-first issue using per-entry age counters;
// when undefined, the lowest-index ready entry issues.
module rs_alu #(
    parameter int RS_SIZE        = 8,
    parameter int ROB_SIZE_WIDTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    rdy,
    input  logic    clear,
    rs_alu_if.slave bus
);
    localparam int IDX_W = $clog2(RS_SIZE);

    typedef logic [ROB_SIZE_WIDTH-1:0] tag_t;
    typedef logic [IDX_W-1:0]          idx_t;

    // entry control state
    logic [RS_SIZE-1:0] valid_q, valid_d;
    logic [RS_SIZE-1:0] p1_q, p1_d;
    logic [RS_SIZE-1:0] p2_q, p2_d;
    // entry payload
    logic [4:0]  op_q  [RS_SIZE];
    logic [4:0]  op_d  [RS_SIZE];
    tag_t        rob_q [RS_SIZE];
    tag_t        rob_d [RS_SIZE];
    tag_t        q1_q  [RS_SIZE];
    tag_t        q1_d  [RS_SIZE];
    tag_t        q2_q  [RS_SIZE];
    tag_t        q2_d  [RS_SIZE];
    logic [31:0] v1_q  [RS_SIZE];
    logic [31:0] v1_d  [RS_SIZE];
    logic [31:0] v2_q  [RS_SIZE];
    logic [31:0] v2_d  [RS_SIZE];
`ifdef RS_AGE_ORDER_EN
    idx_t        age_q [RS_SIZE];
    idx_t        age_d [RS_SIZE];
    idx_t        sel_age;
`endif

    // issue output registers
    logic        issue_valid_q, issue_valid_d;
    logic [4:0]  issue_op_q, issue_op_d;
    logic [31:0] issue_v1_q, issue_v1_d;
    logic [31:0] issue_v2_q, issue_v2_d;
    tag_t        issue_rob_q, issue_rob_d;

    logic [RS_SIZE-1:0] eligible;
    logic               free_found;
    idx_t               free_idx;
    logic               sel_found;
    idx_t               sel_idx;
    logic               dispatch_fire;

    // Resolve a pending operand against both CDBs; ALU bus has priority.
    // Returns {pending, value}.
    function automatic logic [32:0] snoop(
        input logic        pend,
        input tag_t        q,
        input logic [31:0] v,
        input logic        a_rdy,
        input tag_t        a_tag,
        input logic [31:0] a_res,
        input logic        l_rdy,
        input tag_t        l_tag,
        input logic [31:0] l_res
    );
        logic [32:0] r;
        r = {pend, v};
        if (pend) begin
            if (a_rdy && (a_tag == q)) begin
                r = {1'b0, a_res};
            end else if (l_rdy && (l_tag == q)) begin
                r = {1'b0, l_res};
            end
        end
        return r;
    endfunction

    assign eligible = valid_q & ~p1_q & ~p2_q;
    assign bus.full = &valid_q;

    assign bus.issue_valid  = issue_valid_q;
    assign bus.issue_op     = issue_op_q;
    assign bus.issue_v1     = issue_v1_q;
    assign bus.issue_v2     = issue_v2_q;
    assign bus.issue_rob_id = issue_rob_q;

    // Lowest-index slot that is free at the start of the cycle.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = idx_t'(i);
            end
        end
    end

    // Issue pick from registered state: oldest eligible, or lowest-index eligible.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
`ifdef RS_AGE_ORDER_EN
        sel_age   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (eligible[i] && (!sel_found || (age_q[i] > sel_age))) begin
                sel_found = 1'b1;
                sel_idx   = idx_t'(i);
                sel_age   = age_q[i];
            end
        end
`else
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_found = 1'b1;
                sel_idx   = idx_t'(i);
            end
        end
`endif
    end

    assign dispatch_fire = rdy && !clear && bus.dispatch_valid && free_found;

    // Next state: hold on !rdy, flush on clear, otherwise wakeup + issue + dispatch.
    always_comb begin
        valid_d       = valid_q;
        p1_d          = p1_q;
        p2_d          = p2_q;
        op_d          = op_q;
        rob_d         = rob_q;
        q1_d          = q1_q;
        q2_d          = q2_q;
        v1_d          = v1_q;
        v2_d          = v2_q;
`ifdef RS_AGE_ORDER_EN
        age_d         = age_q;
`endif
        issue_valid_d = issue_valid_q;
        issue_op_d    = issue_op_q;
        issue_v1_d    = issue_v1_q;
        issue_v2_d    = issue_v2_q;
        issue_rob_d   = issue_rob_q;

        if (rdy) begin
            if (clear) begin
                valid_d       = '0;
                issue_valid_d = 1'b0;
            end else begin
                // operand wakeup for resident entries
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (valid_q[i]) begin
                        {p1_d[i], v1_d[i]} = snoop(p1_q[i], q1_q[i], v1_q[i],
                            bus.alu_cdb_ready, bus.alu_cdb_rob_id, bus.alu_cdb_result,
                            bus.lsb_cdb_ready, bus.lsb_cdb_rob_id, bus.lsb_cdb_result);
                        {p2_d[i], v2_d[i]} = snoop(p2_q[i], q2_q[i], v2_q[i],
                            bus.alu_cdb_ready, bus.alu_cdb_rob_id, bus.alu_cdb_result,
                            bus.lsb_cdb_ready, bus.lsb_cdb_rob_id, bus.lsb_cdb_result);
                    end
                end

                // issue
                issue_valid_d = sel_found;
                if (sel_found) begin
                    issue_op_d       = op_q[sel_idx];
                    issue_v1_d       = v1_q[sel_idx];
                    issue_v2_d       = v2_q[sel_idx];
                    issue_rob_d      = rob_q[sel_idx];
                    valid_d[sel_idx] = 1'b0;
                end

`ifdef RS_AGE_ORDER_EN
                // issue-side decrement first, then dispatch-side increment
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (valid_q[i] && !(sel_found && (sel_idx == idx_t'(i)))) begin
                        age_d[i] = age_q[i]
                                 - idx_t'(sel_found && (age_q[i] > sel_age))
                                 + idx_t'(dispatch_fire);
                    end
                end
`endif

                // dispatch into the free slot, with same-cycle CDB bypass
                if (dispatch_fire) begin
                    valid_d[free_idx] = 1'b1;
                    op_d[free_idx]    = bus.dispatch_op;
                    rob_d[free_idx]   = bus.dispatch_rob_id;
                    q1_d[free_idx]    = bus.dispatch_q1;
                    q2_d[free_idx]    = bus.dispatch_q2;
                    {p1_d[free_idx], v1_d[free_idx]} = snoop(bus.dispatch_p1, bus.dispatch_q1,
                        bus.dispatch_v1,
                        bus.alu_cdb_ready, bus.alu_cdb_rob_id, bus.alu_cdb_result,
                        bus.lsb_cdb_ready, bus.lsb_cdb_rob_id, bus.lsb_cdb_result);
                    {p2_d[free_idx], v2_d[free_idx]} = snoop(bus.dispatch_p2, bus.dispatch_q2,
                        bus.dispatch_v2,
                        bus.alu_cdb_ready, bus.alu_cdb_rob_id, bus.alu_cdb_result,
                        bus.lsb_cdb_ready, bus.lsb_cdb_rob_id, bus.lsb_cdb_result);
`ifdef RS_AGE_ORDER_EN
                    age_d[free_idx]   = '0;
`endif
                end
            end
        end
    end

    // Entry valid bits and issue outputs, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_op_q    <= '0;
            issue_v1_q    <= '0;
            issue_v2_q    <= '0;
            issue_rob_q   <= '0;
        end else begin
            valid_q       <= valid_d;
            issue_valid_q <= issue_valid_d;
            issue_op_q    <= issue_op_d;
            issue_v1_q    <= issue_v1_d;
            issue_v2_q    <= issue_v2_d;
            issue_rob_q   <= issue_rob_d;
        end
    end

    // Entry payload; only meaningful while the entry's valid bit is set.
    always_ff @(posedge clk) begin
        p1_q  <= p1_d;
        p2_q  <= p2_d;
        op_q  <= op_d;
        rob_q <= rob_d;
        q1_q  <= q1_d;
        q2_q  <= q2_d;
        v1_q  <= v1_d;
        v2_q  <= v2_d;
`ifdef RS_AGE_ORDER_EN
        age_q <= age_d;
`endif
    end
endmodule

// File: tb/tb_rs_alu.sv
// tb_rs_alu: directed and randomized bench for rs_alu against a slot-list reference model.
// Honors RS_AGE_ORDER_EN the same way as the design (oldest dispatch first).
module tb_rs_alu;
    localparam int RS = 8;
    localparam int TW = 4;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic clear;

    always #5 clk = ~clk;

    rs_alu_if #(.ROB_SIZE_WIDTH(TW)) bus ();

    rs_alu #(.RS_SIZE(RS), .ROB_SIZE_WIDTH(TW)) dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .clear (clear),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // reference model: slots plus dispatch sequence numbers
    logic [RS-1:0] m_valid;
    logic [4:0]    m_op  [RS];
    logic [TW-1:0] m_rob [RS];
    logic [31:0]   m_v1  [RS];
    logic [31:0]   m_v2  [RS];
    logic          m_p1  [RS];
    logic          m_p2  [RS];
    logic [TW-1:0] m_q1  [RS];
    logic [TW-1:0] m_q2  [RS];
    int            m_seq [RS];
    int            seq_ctr;
    logic          m_iv;
    logic [4:0]    m_iop;
    logic [31:0]   m_iv1;
    logic [31:0]   m_iv2;
    logic [TW-1:0] m_irob;

    function automatic void model_reset();
        m_valid = '0;
        m_iv = 1'b0; m_iop = '0; m_iv1 = '0; m_iv2 = '0; m_irob = '0;
        seq_ctr = 0;
    endfunction

    function automatic bit cdb_hit(input logic [TW-1:0] q, output logic [31:0] v);
        v = '0;
        if (bus.alu_cdb_ready && bus.alu_cdb_rob_id == q) begin v = bus.alu_cdb_result; return 1'b1; end
        if (bus.lsb_cdb_ready && bus.lsb_cdb_rob_id == q) begin v = bus.lsb_cdb_result; return 1'b1; end
        return 1'b0;
    endfunction

    // One clock edge of the reference model, using the inputs currently driven.
    function automatic void model_step();
        int pick = -1;
        int slot = -1;
        logic [31:0] val;
        bit was_full;
        if (!rdy) return;
        if (clear) begin
            m_valid = '0;
            m_iv = 1'b0;
            return;
        end
        was_full = &m_valid;
        for (int i = RS - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
        for (int i = 0; i < RS; i++) begin
            if (m_valid[i] && !m_p1[i] && !m_p2[i]) begin
`ifdef RS_AGE_ORDER_EN
                if (pick < 0 || m_seq[i] < m_seq[pick]) pick = i;
`else
                if (pick < 0) pick = i;
`endif
            end
        end
        for (int i = 0; i < RS; i++) begin
            if (m_valid[i]) begin
                if (m_p1[i] && cdb_hit(m_q1[i], val)) begin m_p1[i] = 1'b0; m_v1[i] = val; end
                if (m_p2[i] && cdb_hit(m_q2[i], val)) begin m_p2[i] = 1'b0; m_v2[i] = val; end
            end
        end
        if (pick >= 0) begin
            m_iv = 1'b1; m_iop = m_op[pick]; m_iv1 = m_v1[pick]; m_iv2 = m_v2[pick];
            m_irob = m_rob[pick];
            m_valid[pick] = 1'b0;
        end else begin
            m_iv = 1'b0;
        end
        if (bus.dispatch_valid && !was_full) begin
            m_valid[slot] = 1'b1;
            m_op[slot] = bus.dispatch_op;
            m_rob[slot] = bus.dispatch_rob_id;
            m_q1[slot] = bus.dispatch_q1; m_q2[slot] = bus.dispatch_q2;
            m_p1[slot] = bus.dispatch_p1; m_v1[slot] = bus.dispatch_v1;
            m_p2[slot] = bus.dispatch_p2; m_v2[slot] = bus.dispatch_v2;
            if (m_p1[slot] && cdb_hit(m_q1[slot], val)) begin m_p1[slot] = 1'b0; m_v1[slot] = val; end
            if (m_p2[slot] && cdb_hit(m_q2[slot], val)) begin m_p2[slot] = 1'b0; m_v2[slot] = val; end
            m_seq[slot] = seq_ctr;
            seq_ctr++;
        end
    endfunction

    function automatic logic [74:0] dut_vec();
        return {bus.issue_valid, bus.full, bus.issue_op, bus.issue_v1, bus.issue_v2, bus.issue_rob_id};
    endfunction

    function automatic logic [74:0] mdl_vec();
        return {m_iv, &m_valid, m_iop, m_iv1, m_iv2, m_irob};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.dispatch_valid = 1'b0;
        bus.alu_cdb_ready  = 1'b0;
        bus.lsb_cdb_ready  = 1'b0;
    endtask

    task automatic drive_dispatch(input logic [4:0] op, input logic [TW-1:0] rob,
                                  input logic [31:0] v1, input logic p1, input logic [TW-1:0] q1,
                                  input logic [31:0] v2, input logic p2, input logic [TW-1:0] q2);
        bus.dispatch_valid = 1'b1; bus.dispatch_op = op; bus.dispatch_rob_id = rob;
        bus.dispatch_v1 = v1; bus.dispatch_p1 = p1; bus.dispatch_q1 = q1;
        bus.dispatch_v2 = v2; bus.dispatch_p2 = p2; bus.dispatch_q2 = q2;
    endtask

    task automatic test_reset();
        rst = 1'b0; rdy = 1'b1; clear = 1'b0;
        idle();
        bus.dispatch_op = '0; bus.dispatch_rob_id = '0; bus.dispatch_v1 = '0; bus.dispatch_v2 = '0;
        bus.dispatch_p1 = 1'b0; bus.dispatch_p2 = 1'b0; bus.dispatch_q1 = '0; bus.dispatch_q2 = '0;
        bus.alu_cdb_rob_id = '0; bus.alu_cdb_result = '0;
        bus.lsb_cdb_rob_id = '0; bus.lsb_cdb_result = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b want 0", bus.issue_valid); end
        checks++;
        if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
        checks++;
        if ({bus.issue_op, bus.issue_v1, bus.issue_v2, bus.issue_rob_id} !== 73'd0) begin
            errors++; $display("FAIL reset_issue_data: got %h want 0",
                               {bus.issue_op, bus.issue_v1, bus.issue_v2, bus.issue_rob_id});
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        drive_dispatch(5'd0, 4'd6, 32'd3, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0);
        tick();
        idle();
        checks++;
        if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL basic_dispatch: got %h want %h", dut_vec(), mdl_vec()); end
        tick();
        checks++;
        if ({bus.issue_valid, bus.issue_op, bus.issue_v1, bus.issue_v2, bus.issue_rob_id} !==
            {1'b1, 5'd0, 32'd3, 32'd4, 4'd6}) begin
            errors++; $display("FAIL basic_issue: got v=%b op=%0d v1=%0d v2=%0d rob=%0d want v=1 op=0 v1=3 v2=4 rob=6",
                               bus.issue_valid, bus.issue_op, bus.issue_v1, bus.issue_v2, bus.issue_rob_id);
        end
        tick();
        checks++;
        if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL basic_after: issue_valid got %b want 0", bus.issue_valid); end
        checks++;
        if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL basic_hold: got %h want %h", dut_vec(), mdl_vec()); end
    endtask

    task automatic test_wakeup();
        drive_dispatch(5'd3, 4'd7, 32'd0, 1'b1, 4'd2, 32'd7, 1'b0, 4'd0);
        tick();
        idle();
        tick();
        bus.alu_cdb_ready = 1'b1; bus.alu_cdb_rob_id = 4'd2; bus.alu_cdb_result = 32'h10;
        tick();
        idle();
        checks++;
        if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL wakeup_same_cycle: issue_valid got %b want 0", bus.issue_valid); end
        tick();
        checks++;
        if ({bus.issue_valid, bus.issue_v1, bus.issue_v2, bus.issue_rob_id} !== {1'b1, 32'h10, 32'd7, 4'd7}) begin
            errors++; $display("FAIL wakeup_issue: got v=%b v1=%h v2=%h rob=%0d want v=1 v1=10 v2=7 rob=7",
                               bus.issue_valid, bus.issue_v1, bus.issue_v2, bus.issue_rob_id);
        end
        tick();
    endtask

    task automatic test_bypass();
        drive_dispatch(5'd4, 4'd8, 32'h55, 1'b0, 4'd0, 32'd0, 1'b1, 4'd5);
        bus.lsb_cdb_ready = 1'b1; bus.lsb_cdb_rob_id = 4'd5; bus.lsb_cdb_result = 32'hAB;
        tick();
        idle();
        checks++;
        if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL bypass_early: issue_valid got %b want 0", bus.issue_valid); end
        tick();
        checks++;
        if ({bus.issue_valid, bus.issue_v1, bus.issue_v2, bus.issue_rob_id} !== {1'b1, 32'h55, 32'hAB, 4'd8}) begin
            errors++; $display("FAIL bypass_issue: got v=%b v1=%h v2=%h rob=%0d want v=1 v1=55 v2=ab rob=8",
                               bus.issue_valid, bus.issue_v1, bus.issue_v2, bus.issue_rob_id);
        end
        tick();
    endtask

    task automatic test_full();
        for (int k = 0; k < RS; k++) begin
            drive_dispatch(5'(k), 4'(k), 32'(k), 1'b1, 4'd9, 32'(k + 100), 1'b0, 4'd0);
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL fill_%0d: got %h want %h", k, dut_vec(), mdl_vec()); end
        end
        checks++;
        if (bus.full !== 1'b1) begin errors++; $display("FAIL full_set: got %b want 1", bus.full); end
        drive_dispatch(5'd1, 4'd15, 32'd1, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0);
        tick();
        idle();
        checks++;
        if ({bus.full, bus.issue_valid} !== 2'b10) begin
            errors++; $display("FAIL full_ignore: got full=%b iv=%b want full=1 iv=0", bus.full, bus.issue_valid);
        end
        bus.alu_cdb_ready = 1'b1; bus.alu_cdb_rob_id = 4'd9; bus.alu_cdb_result = 32'h99;
        tick();
        idle();
        for (int k = 0; k < RS; k++) begin
            tick();
            checks++;
            if ({bus.issue_valid, bus.issue_rob_id, bus.issue_v1, bus.issue_v2} !== {1'b1, 4'(k), 32'h99, 32'(k + 100)}) begin
                errors++; $display("FAIL drain_%0d: got v=%b rob=%0d v1=%h v2=%0d want v=1 rob=%0d v1=99 v2=%0d",
                                   k, bus.issue_valid, bus.issue_rob_id, bus.issue_v1, bus.issue_v2, k, k + 100);
            end
            if (k == 0) begin
                checks++;
                if (bus.full !== 1'b0) begin errors++; $display("FAIL full_drop: got %b want 0", bus.full); end
            end
        end
        tick();
        checks++;
        if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL drain_end: issue_valid got %b want 0", bus.issue_valid); end
    endtask

    task automatic test_clear();
        drive_dispatch(5'd2, 4'd1, 32'd0, 1'b1, 4'd11, 32'd0, 1'b0, 4'd0);
        tick();
        drive_dispatch(5'd2, 4'd2, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd11);
        tick();
        drive_dispatch(5'd2, 4'd3, 32'd5, 1'b0, 4'd0, 32'd6, 1'b0, 4'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        idle();
        checks++;
        if ({bus.full, bus.issue_valid} !== 2'b00) begin
            errors++; $display("FAIL clear_state: got full=%b iv=%b want 0 0", bus.full, bus.issue_valid);
        end
        bus.alu_cdb_ready = 1'b1; bus.alu_cdb_rob_id = 4'd11; bus.alu_cdb_result = 32'h1;
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL clear_no_issue_%0d: issue_valid got %b want 0", k, bus.issue_valid); end
        end
    endtask

    task automatic test_age();
        logic [TW-1:0] first_rob;
        logic [TW-1:0] second_rob;
        // A (tag 1), B (tag 3), C ready; broadcast tag 3 then tag 1 -> C, B, A
        drive_dispatch(5'd1, 4'd10, 32'd0, 1'b1, 4'd1, 32'd1, 1'b0, 4'd0); tick();
        drive_dispatch(5'd2, 4'd11, 32'd0, 1'b1, 4'd3, 32'd2, 1'b0, 4'd0); tick();
        drive_dispatch(5'd3, 4'd12, 32'd3, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0); tick();
        idle();
        bus.alu_cdb_ready = 1'b1; bus.alu_cdb_rob_id = 4'd3; bus.alu_cdb_result = 32'h33;
        tick();
        checks++;
        if ({bus.issue_valid, bus.issue_rob_id} !== {1'b1, 4'd12}) begin
            errors++; $display("FAIL age_order_c: got v=%b rob=%0d want v=1 rob=12", bus.issue_valid, bus.issue_rob_id);
        end
        bus.alu_cdb_rob_id = 4'd1; bus.alu_cdb_result = 32'h11;
        tick();
        idle();
        checks++;
        if ({bus.issue_valid, bus.issue_rob_id, bus.issue_v1} !== {1'b1, 4'd11, 32'h33}) begin
            errors++; $display("FAIL age_order_b: got v=%b rob=%0d v1=%h want v=1 rob=11 v1=33", bus.issue_valid, bus.issue_rob_id, bus.issue_v1);
        end
        tick();
        checks++;
        if ({bus.issue_valid, bus.issue_rob_id, bus.issue_v1} !== {1'b1, 4'd10, 32'h11}) begin
            errors++; $display("FAIL age_order_a: got v=%b rob=%0d v1=%h want v=1 rob=10 v1=11", bus.issue_valid, bus.issue_rob_id, bus.issue_v1);
        end
        tick();
        // same setup, tags 1 and 3 broadcast together -> C, A, B
        drive_dispatch(5'd1, 4'd10, 32'd0, 1'b1, 4'd1, 32'd1, 1'b0, 4'd0); tick();
        drive_dispatch(5'd2, 4'd11, 32'd0, 1'b1, 4'd3, 32'd2, 1'b0, 4'd0); tick();
        drive_dispatch(5'd3, 4'd12, 32'd3, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0); tick();
        idle();
        bus.alu_cdb_ready = 1'b1; bus.alu_cdb_rob_id = 4'd1; bus.alu_cdb_result = 32'h11;
        bus.lsb_cdb_ready = 1'b1; bus.lsb_cdb_rob_id = 4'd3; bus.lsb_cdb_result = 32'h33;
        tick();
        idle();
        checks++;
        if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL age_pair_c: got %h want %h", dut_vec(), mdl_vec()); end
        tick();
        checks++;
        if ({bus.issue_valid, bus.issue_rob_id} !== {1'b1, 4'd10}) begin
            errors++; $display("FAIL age_pair_first: got v=%b rob=%0d want v=1 rob=10", bus.issue_valid, bus.issue_rob_id);
        end
        tick();
        checks++;
        if ({bus.issue_valid, bus.issue_rob_id} !== {1'b1, 4'd11}) begin
            errors++; $display("FAIL age_pair_second: got v=%b rob=%0d want v=1 rob=11", bus.issue_valid, bus.issue_rob_id);
        end
        tick();
        // younger entry lands in a lower slot than an older one
        drive_dispatch(5'd4, 4'd4, 32'd4, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0); tick();
        drive_dispatch(5'd5, 4'd5, 32'd0, 1'b1, 4'd1, 32'd5, 1'b0, 4'd0); tick();
        drive_dispatch(5'd6, 4'd6, 32'd0, 1'b1, 4'd1, 32'd6, 1'b0, 4'd0); tick();
        idle();
        bus.alu_cdb_ready = 1'b1; bus.alu_cdb_rob_id = 4'd1; bus.alu_cdb_result = 32'h77;
        tick();
        idle();
`ifdef RS_AGE_ORDER_EN
        first_rob = 4'd5; second_rob = 4'd6;
`else
        first_rob = 4'd6; second_rob = 4'd5;
`endif
        tick();
        checks++;
        if ({bus.issue_valid, bus.issue_rob_id} !== {1'b1, first_rob}) begin
            errors++; $display("FAIL age_slot_first: got v=%b rob=%0d want v=1 rob=%0d", bus.issue_valid, bus.issue_rob_id, first_rob);
        end
        tick();
        checks++;
        if ({bus.issue_valid, bus.issue_rob_id} !== {1'b1, second_rob}) begin
            errors++; $display("FAIL age_slot_second: got v=%b rob=%0d want v=1 rob=%0d", bus.issue_valid, bus.issue_rob_id, second_rob);
        end
        tick();
    endtask

    task automatic test_rdy_hold();
        drive_dispatch(5'd9, 4'd13, 32'd1, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0);
        tick();
        idle();
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({bus.issue_valid, bus.full} !== 2'b00 || dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL rdy_hold_%0d: got %h want %h", k, dut_vec(), mdl_vec());
            end
        end
        rdy = 1'b1;
        tick();
        checks++;
        if ({bus.issue_valid, bus.issue_op, bus.issue_rob_id} !== {1'b1, 5'd9, 4'd13}) begin
            errors++; $display("FAIL rdy_resume: got v=%b op=%0d rob=%0d want v=1 op=9 rob=13",
                               bus.issue_valid, bus.issue_op, bus.issue_rob_id);
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rdy   = ($urandom_range(0, 9) != 0);
            clear = ($urandom_range(0, 49) == 0);
            bus.dispatch_valid  = $urandom_range(0, 1);
            bus.dispatch_op     = 5'($urandom);
            bus.dispatch_rob_id = 4'($urandom);
            bus.dispatch_v1     = $urandom;
            bus.dispatch_v2     = $urandom;
            bus.dispatch_p1     = ($urandom_range(0, 2) == 0);
            bus.dispatch_p2     = ($urandom_range(0, 2) == 0);
            bus.dispatch_q1     = 4'($urandom_range(0, 7));
            bus.dispatch_q2     = 4'($urandom_range(0, 7));
            bus.alu_cdb_ready   = ($urandom_range(0, 2) == 0);
            bus.alu_cdb_rob_id  = 4'($urandom_range(0, 7));
            bus.alu_cdb_result  = $urandom;
            bus.lsb_cdb_ready   = ($urandom_range(0, 2) == 0);
            bus.lsb_cdb_rob_id  = 4'($urandom_range(0, 7));
            bus.lsb_cdb_result  = $urandom;
            if (bus.lsb_cdb_rob_id == bus.alu_cdb_rob_id) bus.lsb_cdb_rob_id = bus.alu_cdb_rob_id ^ 4'd8;
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL random_%0d: got %h want %h", n, dut_vec(), mdl_vec());
            end
        end
        idle();
        rdy = 1'b1;
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_bypass();
        test_full();
        test_clear();
        test_age();
        test_rdy_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
